// File: rtl/imm_pkg.sv
// Shared definitions for the immediate field encoder: select codes, field
// geometry per format and the encoder FSM state type.
package imm_pkg;

  localparam int unsigned SEL_W   = 2;
  localparam int unsigned VALUE_W = 64;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned POS_W   = 5;
  localparam int unsigned COUNT_W = 16;

  localparam logic [SEL_W-1:0] SEL_ALU   = 2'b00;
  localparam logic [SEL_W-1:0] SEL_DT    = 2'b01;
  localparam logic [SEL_W-1:0] SEL_SHAMT = 2'b10;
  localparam logic [SEL_W-1:0] SEL_CBR   = 2'b11;

  localparam logic [POS_W-1:0] FIELD_LSB_ALU   = 5'd10;
  localparam logic [POS_W-1:0] FIELD_LSB_DT    = 5'd12;
  localparam logic [POS_W-1:0] FIELD_LSB_SHAMT = 5'd10;
  localparam logic [POS_W-1:0] FIELD_LSB_CBR   = 5'd5;

  localparam logic [POS_W-1:0] FIELD_W_ALU   = 5'd12;
  localparam logic [POS_W-1:0] FIELD_W_DT    = 5'd9;
  localparam logic [POS_W-1:0] FIELD_W_SHAMT = 5'd6;
  localparam logic [POS_W-1:0] FIELD_W_CBR   = 5'd19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2,
    ERR   = 2'd3
  } state_t;

  function automatic logic [POS_W-1:0] field_lsb(input logic [SEL_W-1:0] sel);
    case (sel)
      SEL_ALU:   return FIELD_LSB_ALU;
      SEL_DT:    return FIELD_LSB_DT;
      SEL_SHAMT: return FIELD_LSB_SHAMT;
      default:   return FIELD_LSB_CBR;
    endcase
  endfunction

  function automatic logic [POS_W-1:0] field_w(input logic [SEL_W-1:0] sel);
    case (sel)
      SEL_ALU:   return FIELD_W_ALU;
      SEL_DT:    return FIELD_W_DT;
      SEL_SHAMT: return FIELD_W_SHAMT;
      default:   return FIELD_W_CBR;
    endcase
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational fit check and field insertion: a value fits when it equals the
// sign extension of its own low `width` bits; the field then replaces base bits.
module imm_field_pack
  import imm_pkg::*;
(
  input  logic [SEL_W-1:0]   sel,
  input  logic [WORD_W-1:0]  base,
  input  logic [VALUE_W-1:0] value,
  output logic               fits,
  output logic [WORD_W-1:0]  word
);

  logic [POS_W-1:0]          lsb;
  logic [POS_W-1:0]          width;
  logic [6:0]                shamt;
  logic signed [VALUE_W-1:0] shifted;
  logic signed [VALUE_W-1:0] extended;
  logic [WORD_W-1:0]         mask;

  always_comb begin
    lsb      = field_lsb(sel);
    width    = field_w(sel);
    shamt    = 7'(VALUE_W) - 7'(width);
    // Round trip through sign extension of the low `width` bits.
    shifted  = $signed(value) <<< shamt;
    extended = shifted >>> shamt;
    fits     = (extended == $signed(value));
    mask     = ((32'd1 << width) - 32'd1) << lsb;
    word     = (base & ~mask) | ((value[WORD_W-1:0] << lsb) & mask);
  end

endmodule

// File: rtl/imm_field_encoder.sv
// Program-loader immediate encoder: captures a request, checks the value fits
// the selected field, then writes the packed word or rejects and counts it.
module imm_field_encoder
  import imm_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic [WORD_W-1:0]   in_base,
  input  logic [VALUE_W-1:0]  in_value,
  input  logic [ADDR_W-1:0]   in_addr,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  output logic                err_valid,
  output logic [COUNT_W-1:0]  err_count,
  output logic                busy
);

  state_t              state;
  state_t              state_next;
  logic [SEL_W-1:0]    sel_q;
  logic [WORD_W-1:0]   base_q;
  logic [VALUE_W-1:0]  value_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                fits_c;
  logic [WORD_W-1:0]   word_c;
  logic                in_ready_c;
  logic                busy_c;
  logic                mem_we_c;
  logic                err_valid_c;

  imm_field_pack u_pack (
    .sel   (sel_q),
    .base  (base_q),
    .value (value_q),
    .fits  (fits_c),
    .word  (word_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state plus the registered outputs decoded from it.
  always_comb begin
    state_next  = state;
    case (state)
      IDLE:    if (in_valid) state_next = CHECK;
      CHECK:   state_next = fits_c ? WRITE : ERR;
      WRITE:   if (mem_ack) state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    in_ready_c  = (state_next == IDLE);
    busy_c      = (state_next != IDLE);
    mem_we_c    = (state_next == WRITE);
    err_valid_c = (state_next == ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      mem_we    <= 1'b0;
      err_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err_count <= '0;
    end else begin
      in_ready  <= in_ready_c;
      busy      <= busy_c;
      mem_we    <= mem_we_c;
      err_valid <= err_valid_c;
      if (state == CHECK && fits_c) begin
        mem_addr  <= addr_q;
        mem_wdata <= word_c;
      end
      if (state == ERR && err_count != '1) err_count <= err_count + 16'd1;
    end
  end

  // Request capture; inputs are only looked at while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q   <= '0;
      base_q  <= '0;
      value_q <= '0;
      addr_q  <= '0;
    end else if (state == IDLE && in_valid) begin
      sel_q   <= in_sel;
      base_q  <= in_base;
      value_q <= in_value;
      addr_q  <= in_addr;
    end
  end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Randomized bench for imm_field_encoder against an arithmetic reference model
// of range checking and field replacement.
module tb_imm_field_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [31:0] in_base;
  logic [63:0] in_value;
  logic [9:0]  in_addr;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        err_valid;
  logic [15:0] err_count;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;
  int model_count = 0;

  imm_field_encoder #(.ADDR_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_base   (in_base),
    .in_value  (in_value),
    .in_addr   (in_addr),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .err_valid (err_valid),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: legal range is [-2^(w-1), 2^(w-1)); field = value mod 2^w.
  function automatic void model(input logic [1:0] sel, input logic [31:0] base,
                                input logic [63:0] value, output bit fit,
                                output logic [31:0] word);
    longint lsb, w, sv, lim, fmod, field, oldf, b;
    case (sel)
      2'b00:   begin lsb = 10; w = 12; end
      2'b01:   begin lsb = 12; w = 9;  end
      2'b10:   begin lsb = 10; w = 6;  end
      default: begin lsb = 5;  w = 19; end
    endcase
    sv    = longint'(value);
    lim   = longint'(1) << (w - 1);
    fit   = (sv >= -lim) && (sv < lim);
    fmod  = longint'(1) << w;
    field = ((sv % fmod) + fmod) % fmod;
    b     = longint'({32'd0, base});
    oldf  = (b >> lsb) % fmod;
    word  = 32'(b - oldf * (longint'(1) << lsb) + field * (longint'(1) << lsb));
  endfunction

  task automatic run_req(input logic [1:0] sel, input logic [31:0] base,
                         input logic [63:0] value, input logic [9:0] addr,
                         input int ack_delay);
    bit          fit;
    logic [31:0] exp_word;
    model(sel, base, value, fit, exp_word);
    @(negedge clk);
    check("ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_sel = sel; in_base = base; in_value = value; in_addr = addr;
    @(negedge clk);
    // Junk on the inputs and a stray ack while busy must be ignored.
    in_sel = ~sel; in_base = ~base; in_value = ~value; in_addr = ~addr;
    mem_ack = 1'b1;
    check("check_busy", {61'd0, busy, in_ready, mem_we}, {61'd0, 3'b100});
    @(negedge clk);
    mem_ack = (ack_delay == 0);
    if (fit) begin
      check("we_up", {62'd0, mem_we, err_valid}, 64'b10);
      check("waddr", 64'(mem_addr), 64'(addr));
      check("wdata", 64'(mem_wdata), 64'(exp_word));
      for (int i = 0; i < ack_delay; i++) begin
        @(negedge clk);
        mem_ack = (i == ack_delay - 1);
        check("hold", {mem_we, in_ready, mem_addr, mem_wdata}, {1'b1, 1'b0, addr, exp_word});
      end
      @(negedge clk);
      mem_ack = 1'b0; in_valid = 1'b0;
      check("after_ack", {61'd0, mem_we, in_ready, busy}, {61'd0, 3'b010});
    end else begin
      check("err_pulse", {62'd0, err_valid, mem_we}, 64'b10);
      mem_ack = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      if (model_count < 65535) model_count++;
      check("err_done", {err_valid, mem_we, in_ready, busy}, {4'b0010});
      check("err_count", 64'(err_count), 64'(model_count));
    end
  endtask

  function automatic logic [63:0] pick_value(input logic [1:0] sel);
    longint w, lim;
    int k;
    case (sel)
      2'b00: w = 12; 2'b01: w = 9; 2'b10: w = 6; default: w = 19;
    endcase
    lim = longint'(1) << (w - 1);
    k = $urandom_range(0, 6);
    case (k)
      0: return 64'(-lim);
      1: return 64'(lim - 1);
      2: return 64'(-lim - 1);
      3: return 64'(lim);
      4: return {$urandom, $urandom};
      default: return 64'(longint'($urandom_range(0, 32'(2 * lim - 1))) - lim);
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sel = '0; in_base = '0; in_value = '0;
    in_addr = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", {in_ready, mem_we, err_valid, busy, err_count, mem_addr, mem_wdata},
          {1'b1, 3'b000, 16'd0, 10'd0, 32'd0});
    reset = 1'b0;

    // Directed cases.
    run_req(2'b00, 32'h0, 64'h7FF, 10'd5, 0);
    run_req(2'b11, 32'h5400_0000, '1, 10'd9, 1);
    run_req(2'b11, 32'h5400_0000, 64'h4_0000, 10'd9, 0);
    run_req(2'b10, 32'hFFFF_FFFF, 64'd32, 10'd1, 0);
    run_req(2'b10, 32'h0, 64'(-64'sd32), 10'd2, 0);
    check("shamt_field", 64'(mem_wdata[15:10]), 64'h20);
    run_req(2'b01, 32'h0, 64'(-64'sd256), 10'd3, 0);
    check("dt_field", 64'(mem_wdata[20:12]), 64'h100);
    run_req(2'b00, 32'hA5A5_A5A5, 64'h123, 10'd700, 4);

    // Randomized requests.
    for (int n = 0; n < 300; n++) begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 3));
      run_req(s, $urandom, pick_value(s), 10'($urandom), $urandom_range(0, 4));
    end

    // Saturation: preload the counter just below the top.
    @(negedge clk);
    force dut.err_count = 16'hFFFE;
    #1 release dut.err_count;
    model_count = 16'hFFFE;
    run_req(2'b10, 32'h0, 64'd100, 10'd0, 0);
    run_req(2'b10, 32'h0, 64'd100, 10'd0, 0);

    // Reset during WRITE with a non-zero counter, then a late ack.
    reset = 1'b1; @(negedge clk); reset = 1'b0; model_count = 0;
    for (int i = 0; i < 3; i++) run_req(2'b00, 32'h0, 64'h800, 10'd0, 0);
    check("count3", 64'(err_count), 64'd3);
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'b00; in_value = 64'h5; in_addr = 10'd7; in_base = 32'h0;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_we", 64'(mem_we), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_write", {mem_we, in_ready, busy, err_count}, {3'b010, 16'd0});
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack", {61'd0, mem_we, in_ready, busy}, {61'd0, 3'b010});
    @(negedge clk);
    check("late_ack2", {61'd0, mem_we, in_ready, busy}, {61'd0, 3'b010});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
